// File: rtl/mips_pkg.sv
// Shared register-file types for the writeback path.
// Holds address/data widths and the packed write record that the secondary FIFO carries.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending secondary writebacks; an entry is readable one cycle after push.
// Pushes are ignored when full and pops are ignored when empty; full/empty are registered-pointer based.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   push_i,
  input  rf_wr_t push_dat_i,
  input  logic   pop_i,
  output rf_wr_t head_dat_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  rf_wr_t      mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single regfile write port between primary writeback and buffered long-latency results.
// Same-cycle combinational arbitration; a starved FIFO head stalls primary writeback; pending scoreboard gates issue.
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_wa_i,
  input  logic [DATA_W-1:0]     wb_wd_i,
  output logic                  wb_stall_o,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_wa_i,
  input  logic [DATA_W-1:0]     lu_wd_i,
  output logic                  lu_ready_o,
  input  logic                  iss_valid_i,
  input  logic [REG_ADDR_W-1:0] iss_wa_i,
  output logic                  iss_ready_o,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic                  busy1_o,
  output logic                  busy2_o,
  output logic                  we3_o,
  output logic [REG_ADDR_W-1:0] wa3_o,
  output logic [DATA_W-1:0]     wd3_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_LIMIT);

  rf_wr_t              push_dat;
  rf_wr_t              head;
  logic                fifo_full, fifo_empty;
  logic                fifo_push, fifo_pop;
  logic                prim_req, forced;
  logic [CW-1:0]       wait_q, wait_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                iss_fire, head_clr;

  assign push_dat.wa = lu_wa_i;
  assign push_dat.wd = lu_wd_i;

  // Ready is derived from the registered full flag, so a pop cannot make room in the same cycle.
  assign lu_ready_o = !reset_i && !fifo_full;
  assign fifo_push  = lu_valid_i && lu_ready_o;

  assign prim_req = wb_we_i && (wb_wa_i != '0);
  assign forced   = !fifo_empty && (wait_q == WAIT_MAX);
  assign fifo_pop = !reset_i && !fifo_empty && (forced || !prim_req);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (fifo_push),
    .push_dat_i (push_dat),
    .pop_i      (fifo_pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    we3_o      = 1'b0;
    wa3_o      = '0;
    wd3_o      = '0;
    wb_stall_o = 1'b0;
    if (!reset_i) begin
      if (fifo_pop) begin
        // Entries aimed at r0 are drained silently.
        we3_o      = (head.wa != '0);
        wa3_o      = head.wa;
        wd3_o      = head.wd;
        wb_stall_o = forced && prim_req;
      end else if (prim_req) begin
        we3_o = 1'b1;
        wa3_o = wb_wa_i;
        wd3_o = wb_wd_i;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || fifo_pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign iss_ready_o = !reset_i && (!pending_q[iss_wa_i] || (iss_wa_i == '0));
  assign iss_fire    = iss_valid_i && iss_ready_o && (iss_wa_i != '0);
  assign head_clr    = fifo_pop && (head.wa != '0);

  // Clear first, then set, so a same-cycle set on the same register survives.
  always_comb begin
    pending_d = pending_q;
    if (head_clr) begin
      pending_d = pending_d & ~reg_onehot(head.wa);
    end
    if (iss_fire) begin
      pending_d = pending_d | reg_onehot(iss_wa_i);
    end
  end

  assign busy1_o = !reset_i && pending_q[ra1_i] && (ra1_i != '0);
  assign busy2_o = !reset_i && pending_q[ra2_i] && (ra2_i != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_q    <= '0;
      pending_q <= '0;
    end else begin
      wait_q    <= wait_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected regfile writes queued as stimulus is driven, checked as we3_o fires.
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic [31:0] wb_wd_i;
  logic        wb_stall_o;
  logic        lu_valid_i;
  logic [4:0]  lu_wa_i;
  logic [31:0] lu_wd_i;
  logic        lu_ready_o;
  logic        iss_valid_i;
  logic [4:0]  iss_wa_i;
  logic        iss_ready_o;
  logic [4:0]  ra1_i, ra2_i;
  logic        busy1_o, busy2_o;
  logic        we3_o;
  logic [4:0]  wa3_o;
  logic [31:0] wd3_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [36:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wb_we_i     (wb_we_i),
    .wb_wa_i     (wb_wa_i),
    .wb_wd_i     (wb_wd_i),
    .wb_stall_o  (wb_stall_o),
    .lu_valid_i  (lu_valid_i),
    .lu_wa_i     (lu_wa_i),
    .lu_wd_i     (lu_wd_i),
    .lu_ready_o  (lu_ready_o),
    .iss_valid_i (iss_valid_i),
    .iss_wa_i    (iss_wa_i),
    .iss_ready_o (iss_ready_o),
    .ra1_i       (ra1_i),
    .ra2_i       (ra2_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .we3_o       (we3_o),
    .wa3_o       (wa3_o),
    .wd3_o       (wd3_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
    exp_q.push_back({wa, wd});
  endtask

  task automatic prim(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    wb_we_i = we;
    wb_wa_i = wa;
    wb_wd_i = wd;
  endtask

  task automatic lu(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    lu_valid_i = v;
    lu_wa_i    = wa;
    lu_wd_i    = wd;
  endtask

  // Every regfile write, mid-cycle, must match the next queued expectation.
  always @(negedge clk_i) begin
    if (we3_o) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {27'd0, wa3_o, wd3_o}, 64'd0);
      end else begin
        chk("wr", {27'd0, wa3_o, wd3_o}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    prim(1'b0, 5'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0);
    iss_valid_i = 1'b0;
    iss_wa_i    = 5'd0;
    ra1_i       = 5'd0;
    ra2_i       = 5'd0;
    tick();
    tick();
    settle();
    chk("rst_we3", we3_o, 0);
    chk("rst_lu_ready", lu_ready_o, 0);
    chk("rst_iss_ready", iss_ready_o, 0);
    chk("rst_stall", wb_stall_o, 0);

    // Issue r5, push its result three cycles later.
    tick();
    reset_i = 1'b0;
    iss_valid_i = 1'b1; iss_wa_i = 5'd5; ra1_i = 5'd5;
    settle();
    chk("iss_ready_r5", iss_ready_o, 1);
    chk("busy_r5_same_cycle", busy1_o, 0);
    tick();
    iss_valid_i = 1'b0;
    settle();
    chk("busy_r5_after_issue", busy1_o, 1);
    tick();
    tick();
    lu(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    settle();
    chk("lu_ready_empty", lu_ready_o, 1);
    chk("no_bypass_we3", we3_o, 0);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    settle();
    chk("lu_pop_we3", we3_o, 1);
    chk("lu_pop_wa3", wa3_o, 5);
    chk("busy_r5_at_write", busy1_o, 1);
    tick();
    settle();
    chk("busy_r5_cleared", busy1_o, 0);

    // Starvation: primary writes r3 every cycle while r7 result waits.
    for (int i = 0; i < 5; i++) begin
      tick();
      prim(1'b1, 5'd3, 32'h300 + i);
      if (i == 0) lu(1'b1, 5'd7, 32'h1234);
      else        lu(1'b0, 5'd0, 32'd0);
      expect_wr(5'd3, 32'h300 + i);
      settle();
      chk("starve_stall_lo", wb_stall_o, 0);
    end
    tick();
    prim(1'b1, 5'd3, 32'h305);
    expect_wr(5'd7, 32'h1234);
    settle();
    chk("forced_stall", wb_stall_o, 1);
    chk("forced_wa3", wa3_o, 7);
    tick();
    expect_wr(5'd3, 32'h305);
    settle();
    chk("resume_stall", wb_stall_o, 0);

    // Fill the FIFO behind a busy primary, third push held off.
    tick();
    prim(1'b1, 5'd4, 32'h400); lu(1'b1, 5'd10, 32'hA0);
    expect_wr(5'd4, 32'h400);
    settle();
    tick();
    prim(1'b1, 5'd4, 32'h401); lu(1'b1, 5'd11, 32'hA1);
    expect_wr(5'd4, 32'h401);
    settle();
    chk("fill_ready_one", lu_ready_o, 1);
    tick();
    prim(1'b1, 5'd4, 32'h402); lu(1'b1, 5'd12, 32'hA2);
    expect_wr(5'd4, 32'h402);
    settle();
    chk("full_ready", lu_ready_o, 0);
    tick();
    prim(1'b0, 5'd0, 32'd0);
    expect_wr(5'd10, 32'hA0);
    settle();
    chk("full_pop_ready", lu_ready_o, 0);
    tick();
    expect_wr(5'd11, 32'hA1);
    settle();
    chk("ready_after_pop", lu_ready_o, 1);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    expect_wr(5'd12, 32'hA2);
    settle();
    chk("third_entry_we3", we3_o, 1);

    // Primary to r0 is not a request: the FIFO head wins without stalling.
    tick();
    prim(1'b1, 5'd0, 32'hFFFF); lu(1'b1, 5'd13, 32'hB0);
    settle();
    chk("r0_empty_we3", we3_o, 0);
    tick();
    lu(1'b1, 5'd0, 32'hC0);
    expect_wr(5'd13, 32'hB0);
    settle();
    chk("r0_prim_stall", wb_stall_o, 0);
    chk("r0_prim_wa3", wa3_o, 13);
    tick();
    prim(1'b0, 5'd0, 32'd0); lu(1'b0, 5'd0, 32'd0);
    settle();
    chk("lu_r0_dropped", we3_o, 0);

    // WAW reservation block and busy on both read ports.
    tick();
    iss_valid_i = 1'b1; iss_wa_i = 5'd9;
    settle();
    chk("iss_r9_first", iss_ready_o, 1);
    tick();
    ra1_i = 5'd9; ra2_i = 5'd9;
    settle();
    chk("iss_r9_again", iss_ready_o, 0);
    chk("busy1_r9", busy1_o, 1);
    chk("busy2_r9", busy2_o, 1);
    tick();
    iss_valid_i = 1'b0; iss_wa_i = 5'd0; ra1_i = 5'd0;
    lu(1'b1, 5'd9, 32'h99);
    expect_wr(5'd9, 32'h99);
    settle();
    chk("busy1_r0", busy1_o, 0);
    chk("iss_ready_r0", iss_ready_o, 1);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    settle();
    tick();
    settle();
    chk("busy2_r9_cleared", busy2_o, 0);

    // Reset with a full FIFO and a pending reservation discards everything.
    tick();
    prim(1'b1, 5'd4, 32'h500); lu(1'b1, 5'd20, 32'hE0);
    iss_valid_i = 1'b1; iss_wa_i = 5'd22; ra1_i = 5'd22;
    expect_wr(5'd4, 32'h500);
    settle();
    tick();
    prim(1'b1, 5'd4, 32'h501); lu(1'b1, 5'd21, 32'hE1);
    iss_valid_i = 1'b0;
    expect_wr(5'd4, 32'h501);
    settle();
    chk("pre_rst_busy22", busy1_o, 1);
    tick();
    reset_i = 1'b1;
    lu(1'b0, 5'd0, 32'd0);
    settle();
    chk("mid_rst_we3", we3_o, 0);
    chk("mid_rst_stall", wb_stall_o, 0);
    chk("mid_rst_busy", busy1_o, 0);
    tick();
    reset_i = 1'b0;
    prim(1'b0, 5'd0, 32'd0);
    settle();
    chk("post_rst_ready", lu_ready_o, 1);
    chk("post_rst_busy22", busy1_o, 0);
    chk("post_rst_we3", we3_o, 0);
    tick();
    settle();
    chk("post_rst_no_stale", we3_o, 0);
    tick();
    tick();
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
